// File: rtl/uart_rx.sv
// DZ11 line receiver: recovers async serial characters from rxd using the 16x baud enable,
// and holds each character with its parity, framing and overrun status for the receive silo.
module uart_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clken,
   input  logic [1:0] length,
   input  logic       parEN,
   input  logic       parODD,
   input  logic       rxd,
   input  logic       rxclr,
   output logic [7:0] rxdata,
   output logic       rxfull,
   output logic       rxperr,
   output logic       rxferr,
   output logic       rxovre
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP,
      ST_BREAK
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [3:0]             cnt_q, cnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   load;
   logic                   rxs;
   logic                   mid_bit;
   logic                   last_bit;

   logic [7:0] rxdata_q;
   logic       rxfull_q, rxperr_q, rxferr_q, rxovre_q;

   logic [7:0] data_mask;
   logic [7:0] data_masked;
   logic       par_err;

   // Synchronizer resets to mark so a reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      end
   end

   assign rxs      = sync_q[SYNC_STAGES-1];
   assign mid_bit  = (cnt_q == 4'd15);
   // Compare with >= so a live length change cannot trap the FSM in DATA.
   assign last_bit = ({1'b0, bit_q} >= ({2'b00, length} + 4'd4));

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      load    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (clken && !rxs) begin
               state_d = ST_START;
               cnt_d   = 4'd0;
            end
         end
         ST_START: begin
            if (clken) begin
               if (cnt_q == 4'd7) begin
                  if (!rxs) begin
                     state_d = ST_DATA;
                     cnt_d   = 4'd0;
                     bit_d   = 3'd0;
                     shift_d = 8'h00;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (clken) begin
               cnt_d = cnt_q + 4'd1;
               if (mid_bit) begin
                  shift_d[bit_q] = rxs;
                  bit_d          = bit_q + 3'd1;
                  if (last_bit) begin
                     state_d = parEN ? ST_PAR : ST_STOP;
                  end
               end
            end
         end
         ST_PAR: begin
            if (clken) begin
               cnt_d = cnt_q + 4'd1;
               if (mid_bit) begin
                  par_d   = rxs;
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (clken) begin
               cnt_d = cnt_q + 4'd1;
               if (mid_bit) begin
                  load    = 1'b1;
                  state_d = rxs ? ST_IDLE : ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // Held-low line: wait for mark on any clk so it yields a single frame.
            if (rxs) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
      end
   end

   assign data_mask   = 8'hFF >> (2'd3 - length);
   assign data_masked = shift_q & data_mask;
   assign par_err     = parEN & ((^data_masked ^ par_q) != parODD);

   // A load beats a coincident rxclr: the new character stays unread.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxdata_q <= 8'h00;
         rxfull_q <= 1'b0;
         rxperr_q <= 1'b0;
         rxferr_q <= 1'b0;
         rxovre_q <= 1'b0;
      end else if (load) begin
         rxdata_q <= data_masked;
         rxferr_q <= ~rxs;
         rxperr_q <= par_err;
         rxovre_q <= rxfull_q & ~rxclr;
         rxfull_q <= 1'b1;
      end else if (rxclr) begin
         rxfull_q <= 1'b0;
      end
   end

   assign rxdata = rxdata_q;
   assign rxfull = rxfull_q;
   assign rxperr = rxperr_q;
   assign rxferr = rxferr_q;
   assign rxovre = rxovre_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of character formats plus hand-written
// sequences for latency, break, overrun/rxclr collision, glitch and mid-frame reset.
module tb_uart_rx;

   localparam int SYNC_STAGES = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       clken;
   logic [1:0] length;
   logic       parEN;
   logic       parODD;
   logic       rxd;
   logic       rxclr;
   logic [7:0] rxdata;
   logic       rxfull;
   logic       rxperr;
   logic       rxferr;
   logic       rxovre;

   int n_cmp = 0;
   int n_err = 0;

   uart_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk    (clk),
      .rst    (rst),
      .clken  (clken),
      .length (length),
      .parEN  (parEN),
      .parODD (parODD),
      .rxd    (rxd),
      .rxclr  (rxclr),
      .rxdata (rxdata),
      .rxfull (rxfull),
      .rxperr (rxperr),
      .rxferr (rxferr),
      .rxovre (rxovre)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string      name;
      logic [1:0] len;
      logic       pen;
      logic       podd;
      logic [7:0] data;
      logic       pbit;
      logic       sbit;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) tick();
   endtask

   task automatic pulse_clr();
      rxclr = 1'b1;
      tick();
      rxclr = 1'b0;
   endtask

   // 16 clk per bit with clken tied high; leaves rxd at the stop-bit level.
   task automatic send(input logic [7:0] d, input int nbits, input logic pen,
                       input logic pbit, input logic sbit);
      rxd = 1'b0;
      repeat (16) tick();
      for (int i = 0; i < nbits; i++) begin
         rxd = d[i];
         repeat (16) tick();
      end
      if (pen) begin
         rxd = pbit;
         repeat (16) tick();
      end
      rxd = sbit;
      repeat (16) tick();
   endtask

   task automatic set_fmt(input logic [1:0] len, input logic pen, input logic podd);
      length = len;
      parEN  = pen;
      parODD = podd;
   endtask

   initial begin
      int lat;
      int loads;
      logic prev_full;

      //            name        len    pen   podd  data   pbit  sbit  exp    perr  ferr
      vecs[0] = '{"8N1_C3",  2'd3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
      vecs[1] = '{"7E1_41p0",2'd2, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0};
      vecs[2] = '{"7E1_41p1",2'd2, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
      vecs[3] = '{"5O1_1Fp0",2'd0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0};
      vecs[4] = '{"6E1_2Ap1",2'd1, 1'b1, 1'b0, 8'h2A, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
      vecs[5] = '{"8O1_FFp0",2'd3, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{"8N1_5As0",2'd3, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
      vecs[7] = '{"6N1_FF",  2'd1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h3F, 1'b0, 1'b0};

      rst   = 1'b1;
      clken = 1'b1;
      rxd   = 1'b1;
      rxclr = 1'b0;
      set_fmt(2'd3, 1'b0, 1'b0);
      repeat (4) tick();
      rst = 1'b0;
      tick();
      check("reset_rxdata", rxdata, 8'h00);
      check("reset_rxfull", rxfull, 1'b0);
      check("reset_rxperr", rxperr, 1'b0);
      check("reset_rxferr", rxferr, 1'b0);
      check("reset_rxovre", rxovre, 1'b0);

      // 8N1 0x55: measure clk edges from start-bit drive to rxfull.
      idle(16);
      lat = 0;
      fork
         send(8'h55, 8, 1'b0, 1'b0, 1'b1);
         begin
            for (int i = 1; i <= 200; i++) begin
               tick();
               if (rxfull && lat == 0) lat = i;
            end
         end
      join
      n_cmp++;
      if (lat < 152 || lat > 152 + SYNC_STAGES + 1) begin
         n_err++;
         $display("FAIL latency: got %0d clk, required 152..%0d clk", lat, 152 + SYNC_STAGES + 1);
      end
      if (lat == 0) lat = 152 + SYNC_STAGES + 1;
      idle(16);
      check("8N1_55_data", rxdata, 8'h55);
      check("8N1_55_perr", rxperr, 1'b0);
      check("8N1_55_ferr", rxferr, 1'b0);
      check("8N1_55_ovre", rxovre, 1'b0);

      for (int v = 0; v < 8; v++) begin
         set_fmt(vecs[v].len, vecs[v].pen, vecs[v].podd);
         pulse_clr();
         idle(16);
         send(vecs[v].data, int'(vecs[v].len) + 5, vecs[v].pen, vecs[v].pbit, vecs[v].sbit);
         idle(32);
         check({vecs[v].name, "_full"}, rxfull, 1'b1);
         check({vecs[v].name, "_data"}, rxdata, vecs[v].exp_data);
         check({vecs[v].name, "_perr"}, rxperr, vecs[v].exp_perr);
         check({vecs[v].name, "_ferr"}, rxferr, vecs[v].exp_ferr);
         check({vecs[v].name, "_ovre"}, rxovre, 1'b0);
      end

      // Framing error followed by a held-low line: exactly one load.
      set_fmt(2'd3, 1'b0, 1'b0);
      pulse_clr();
      idle(16);
      send(8'hA5, 8, 1'b0, 1'b0, 1'b0);
      check("brk_full", rxfull, 1'b1);
      check("brk_data", rxdata, 8'hA5);
      check("brk_ferr", rxferr, 1'b1);
      rxclr = 1'b1;
      tick();
      rxclr = 1'b0;
      loads = 0;
      prev_full = rxfull;
      for (int i = 0; i < 800; i++) begin
         tick();
         if (rxfull && !prev_full) loads++;
         prev_full = rxfull;
      end
      check("brk_extra_loads", loads, 0);
      idle(32);
      send(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      idle(16);
      check("brk_after_full", rxfull, 1'b1);
      check("brk_after_data", rxdata, 8'h3C);
      check("brk_after_ferr", rxferr, 1'b0);

      // Overrun, then rxclr colliding with a load.
      pulse_clr();
      idle(16);
      send(8'h11, 8, 1'b0, 1'b0, 1'b1);
      idle(16);
      send(8'h22, 8, 1'b0, 1'b0, 1'b1);
      idle(16);
      check("ovr_data", rxdata, 8'h22);
      check("ovr_ovre", rxovre, 1'b1);
      check("ovr_full", rxfull, 1'b1);
      fork
         send(8'h33, 8, 1'b0, 1'b0, 1'b1);
         begin
            repeat (lat - 1) tick();
            rxclr = 1'b1;
            tick();
            rxclr = 1'b0;
         end
      join
      idle(16);
      check("clr_load_full", rxfull, 1'b1);
      check("clr_load_ovre", rxovre, 1'b0);
      check("clr_load_data", rxdata, 8'h33);
      pulse_clr();
      check("clr_full", rxfull, 1'b0);
      check("clr_keeps_data", rxdata, 8'h33);

      // Short low glitch must not start a frame.
      idle(16);
      rxd = 1'b0;
      repeat (4) tick();
      idle(60);
      check("glitch_full", rxfull, 1'b0);
      check("glitch_data", rxdata, 8'h33);

      // Reset in the middle of data bit 3, then a clean frame.
      fork
         send(8'h7E, 8, 1'b0, 1'b0, 1'b1);
         begin
            repeat (16 * 4 + 8) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
            check("rst_mid_data", rxdata, 8'h00);
            check("rst_mid_full", rxfull, 1'b0);
            check("rst_mid_perr", rxperr, 1'b0);
            check("rst_mid_ferr", rxferr, 1'b0);
            check("rst_mid_ovre", rxovre, 1'b0);
         end
      join
      idle(200);
      pulse_clr();
      idle(16);
      send(8'h7E, 8, 1'b0, 1'b0, 1'b1);
      idle(16);
      check("rst_after_full", rxfull, 1'b1);
      check("rst_after_data", rxdata, 8'h7E);
      check("rst_after_ferr", rxferr, 1'b0);
      check("rst_after_ovre", rxovre, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
DZ11 UART receiver. Recovers asynchronous serial characters from one line, using the 16x baud clock-enable pulse from the fractional-N baud rate generator.
- Supports 5–8 data bits, optional odd/even parity and one stop bit.
- Presents each character with parity, framing and overrun status to the DZ11 receive silo logic.
- Sits between the line's rxd pin and the silo, paired per line with the transmitter.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the rxd metastability synchronizer (minimum 2).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
clken  input  1  16x baud clock enable from the BRG; one-clk pulse per 1/16 bit time
length  input  2  character length: 00=5, 01=6, 10=7, 11=8 data bits
parEN  input  1  parity bit present and checked
parODD  input  1  1=odd parity, 0=even parity
rxd  input  1  asynchronous serial input; idle/mark = 1
rxclr  input  1  one-clk pulse: silo has taken rxdata
rxdata  output  8  received character, LSB = first data bit; unused upper bits 0
rxfull  output  1  rxdata holds an unread character
rxperr  output  1  parity error for the character in rxdata
rxferr  output  1  framing error (stop bit = 0) for the character in rxdata
rxovre  output  1  overrun: the character in rxdata replaced an unread one

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state changes occur on posedge clk; rst has priority over everything.
- Reset values:
  - synchronizer flops = 1
  - state = IDLE, sample counter = 0, bit counter = 0, shift register = 0
  - rxdata = 0; rxfull, rxperr, rxferr, rxovre = 0
- Synchronizer: rxd passes through SYNC_STAGES flops; rxs is the last stage. All decisions use rxs only.
- Counters:
  - Sample counter is 4 bits; it advances only on clk cycles with clken = 1, wraps 15 -> 0.
  - Bit counter is 3 bits.
- State machine (all transitions qualified by clken = 1 unless noted):
  - IDLE: if rxs = 0 -> START, sample counter = 0.
  - START: increment the counter. At the 8th clken (counter 7, mid start bit), sample rxs.
    - rxs = 0: -> DATA, counter = 0, bit counter = 0.
    - rxs = 1: false start/glitch -> IDLE, nothing loaded.
  - DATA: on each 16th clken (counter 15 -> 0, mid bit), store rxs at shift[bitcnt] and increment bitcnt.
    - After bit number (length+5) is stored: -> PAR if parEN, else -> STOP.
  - PAR: sample the parity bit on the 16th clken, then -> STOP.
  - STOP: sample rxs on the 16th clken, then perform a load.
    - Stop sample = 1: -> IDLE.
    - Stop sample = 0: -> BREAK.
  - BREAK: stay until rxs = 1 (checked every clk, not qualified by clken), then -> IDLE. This prevents a held-low line from generating repeated frames.
- Load, on the same clk as the stop sample:
  - rxdata <= shift register with bits above length forced to 0.
  - rxferr <= ~stop sample.
  - rxperr <= parEN & (XOR(data bits, parity bit) != parODD); rxperr = 0 when parEN = 0.
  - rxovre <= rxfull & ~rxclr.
  - rxfull <= 1.
- rxclr:
  - Clears rxfull on the next edge.
  - If it coincides with a load, the load wins: rxfull stays 1 and rxovre = 0.
  - It does not change rxdata or the error flags.
- Latency: rxfull rises on the clk edge that processes the stop-bit mid-sample clken.
- clken = 0 continuously: the FSM freezes in its current state.
- length, parEN and parODD are sampled live. Changing them mid-frame is undefined and must not hang the FSM: a bit counter exceeding length exits DATA.
- rst mid-frame: the frame is abandoned, no load occurs, all outputs return to reset values.

Test Plan:
- 8N1, clken tied 1, send 0x55 (16 clk/bit) -> rxdata = 0x55, rxfull = 1 exactly 9.5 bit times (152 clk ±SYNC_STAGES) after the start-bit falling edge; perr = ferr = ovre = 0.
- 7E1 (length = 10, parEN = 1, parODD = 0): send 0x41 with parity 0 -> rxdata = 0x41, rxperr = 0. Resend 0x41 with parity 1 -> rxperr = 1.
- 5O1 (length = 00, parODD = 1): send 0x1F with parity 0 -> rxdata = 0x1F, upper bits 0, rxperr = 0.
- Framing and break: 8N1, send 0xA5 with stop = 0 -> rxferr = 1. Hold rxd low for 5 more frames -> exactly one load. Release the line, send 0x3C -> rxdata = 0x3C, rxferr = 0.
- Overrun: send 0x11 then 0x22 without rxclr -> rxdata = 0x22, rxovre = 1. Pulse rxclr on the same clk as the 0x33 load -> rxfull = 1, rxovre = 0.
- Glitch and reset: 4-clk low pulse on rxd -> no load, FSM returns to IDLE. Assert rst in the middle of data bit 3 of 0x7E -> all outputs 0; the next frame 0x7E is received correctly.
